// File: rtl/fpmul_issue_ctrl.sv
// Issue controller for a start/done floating-point multiplier: buffers operand pairs,
// runs one multiply at a time under a timeout guard and returns product plus flags.
module fpmul_issue_ctrl #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_a_i,
    input  logic [31:0] in_b_i,
    output logic [31:0] mul_a_o,
    output logic [31:0] mul_b_o,
    output logic        mul_start_o,
    input  logic        mul_done_i,
    input  logic [31:0] mul_product_i,
    input  logic [3:0]  mul_flags_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_product_o,
    output logic [4:0]  res_flags_o,
    output logic [15:0] issued_cnt_o,
    output logic [7:0]  timeout_cnt_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PW-1:0] FULL_CNT   = PW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]   QNAN       = 32'h7FC0_0000;

    typedef enum logic [1:0] {StIdle, StStart, StWait, StHold} state_e;

    state_e        state_q;
    logic [31:0]   mem_a [DEPTH];
    logic [31:0]   mem_b [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] count;
    logic [TW-1:0] timer_q;
    logic          push;
    logic          empty;
    logic          full;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count      = wr_ptr_q - rd_ptr_q;
    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign in_ready_o = !full;
    assign push       = in_valid_i && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr_q[AW-1:0]] <= in_a_i;
            mem_b[wr_ptr_q[AW-1:0]] <= in_b_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            timer_q       <= '0;
            mul_a_o       <= '0;
            mul_b_o       <= '0;
            mul_start_o   <= 1'b0;
            res_valid_o   <= 1'b0;
            res_product_o <= '0;
            res_flags_o   <= '0;
            issued_cnt_o  <= '0;
            timeout_cnt_o <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (!empty) begin
                        mul_a_o     <= mem_a[rd_ptr_q[AW-1:0]];
                        mul_b_o     <= mem_b[rd_ptr_q[AW-1:0]];
                        rd_ptr_q    <= rd_ptr_q + PW'(1);
                        mul_start_o <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    mul_start_o  <= 1'b0;
                    issued_cnt_o <= issued_cnt_o + 16'd1;
                    timer_q      <= '0;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (mul_done_i) begin
                        res_product_o <= mul_product_i;
                        res_flags_o   <= {1'b0, mul_flags_i};
                        res_valid_o   <= 1'b1;
                        state_q       <= StHold;
                    end else if (timer_q == TIMER_LAST) begin
                        // Report a quiet NaN; any done arriving later finds us out of WAIT.
                        res_product_o <= QNAN;
                        res_flags_o   <= 5'b10000;
                        res_valid_o   <= 1'b1;
                        if (timeout_cnt_o != 8'hFF) begin
                            timeout_cnt_o <= timeout_cnt_o + 8'd1;
                        end
                        state_q <= StHold;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                StHold: begin
                    if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_issue_ctrl.sv
// Directed bench for fpmul_issue_ctrl with a table-driven multiplier model.
module tb_fpmul_issue_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TMO   = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_start;
    logic        mul_done = 1'b0;
    logic [31:0] mul_product = '0;
    logic [3:0]  mul_flags = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_product;
    logic [4:0]  res_flags;
    logic [15:0] issued_cnt;
    logic [7:0]  timeout_cnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Operand pairs with hand-computed IEEE-754 products and {nan,inf,ovf,unf} flags.
    logic [31:0] tab_a [9] = '{32'h40400000, 32'h3F800000, 32'h40000000, 32'h3FC00000,
                               32'hBF800000, 32'h3F000000, 32'h40400000, 32'h00000000,
                               32'h7F000000};
    logic [31:0] tab_b [9] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h40000000,
                               32'h40000000, 32'h40800000, 32'h40400000, 32'h40A00000,
                               32'h40800000};
    logic [31:0] tab_p [9] = '{32'h40C00000, 32'h3F800000, 32'h40800000, 32'h40400000,
                               32'hC0000000, 32'h40000000, 32'h41100000, 32'h00000000,
                               32'h7F800000};
    logic [3:0]  tab_f [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
                               4'b0000, 4'b0000, 4'b0010};

    fpmul_issue_ctrl #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_a_i        (in_a),
        .in_b_i        (in_b),
        .mul_a_o       (mul_a),
        .mul_b_o       (mul_b),
        .mul_start_o   (mul_start),
        .mul_done_i    (mul_done),
        .mul_product_i (mul_product),
        .mul_flags_i   (mul_flags),
        .res_valid_o   (res_valid),
        .res_ready_i   (res_ready),
        .res_product_o (res_product),
        .res_flags_o   (res_flags),
        .issued_cnt_o  (issued_cnt),
        .timeout_cnt_o (timeout_cnt)
    );

    always #5 clk = ~clk;

    // Multiplier model: done pulses mdl_lat cycles after the start cycle; 0 means never.
    int mdl_lat = 1;
    int mdl_cnt = 0;
    always @(negedge clk) begin
        mul_done = 1'b0;
        if (mul_start) begin
            mdl_cnt = mdl_lat;
        end else if (mdl_cnt > 0) begin
            mdl_cnt = mdl_cnt - 1;
            if (mdl_cnt == 0) begin
                mul_done    = 1'b1;
                mul_product = 32'hDEADBEEF;
                mul_flags   = 4'b0000;
                for (int i = 0; i < 9; i++) begin
                    if (mul_a == tab_a[i] && mul_b == tab_b[i]) begin
                        mul_product = tab_p[i];
                        mul_flags   = tab_f[i];
                    end
                end
            end
        end
    end

    // Monitor: start/valid timestamps, accepted results, and valid without a prior start.
    int          cyc = 0;
    int          orphans = 0;
    bit          armed = 1'b0;
    bit          prev_valid = 1'b0;
    int          start_cyc [$];
    int          valid_cyc [$];
    logic [31:0] res_p [$];
    logic [4:0]  res_f [$];
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mul_start) begin
            start_cyc.push_back(cyc);
            armed = 1'b1;
        end
        if (res_valid && !prev_valid) begin
            valid_cyc.push_back(cyc);
            if (!armed) orphans = orphans + 1;
            armed = 1'b0;
        end
        prev_valid = res_valid;
        if (res_valid && res_ready) begin
            res_p.push_back(res_product);
            res_f.push_back(res_flags);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_results(input int n, input string tag);
        int k;
        k = 0;
        while (res_p.size() < n && k < 400) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (res_p.size() < n) begin
            n_fail++;
            $display("FAIL %s: got %0d results, want %0d", tag, res_p.size(), n);
        end
    endtask

    task automatic test_reset();
        logic [127:0] snap;
        #1 rst_n = 1'b0;
        #2;
        snap = {mul_a, mul_b, mul_start, res_valid, res_product, res_flags, issued_cnt,
                timeout_cnt, in_ready};
        n_cmp++;
        if (snap !== 128'h1) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h want %h", snap, 128'h1);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_single_op();
        bit ok;
        int rb, sb, vb;
        rb = res_p.size();
        sb = start_cyc.size();
        vb = valid_cyc.size();
        mdl_lat   = 3;
        res_ready = 1'b1;
        push(tab_a[0], tab_b[0], ok);
        @(negedge clk);
        n_cmp++;
        if (mul_start !== 1'b0) begin
            n_fail++;
            $display("FAIL single_start_early: got %b want 0", mul_start);
        end
        @(negedge clk);
        n_cmp++;
        if ({mul_start, mul_a, mul_b} !== {1'b1, tab_a[0], tab_b[0]}) begin
            n_fail++;
            $display("FAIL single_start_cycle: got %b %h %h want 1 %h %h",
                     mul_start, mul_a, mul_b, tab_a[0], tab_b[0]);
        end
        @(posedge clk);
        #1;
        wait_results(rb + 1, "single_wait");
        step(3);
        n_cmp++;
        if ({res_p[rb], res_f[rb]} !== {32'h40C00000, 5'b00000}) begin
            n_fail++;
            $display("FAIL single_result: got %h/%b want 40c00000/00000", res_p[rb], res_f[rb]);
        end
        n_cmp++;
        if (issued_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL single_issued: got %0d want 1", issued_cnt);
        end
        n_cmp++;
        if (start_cyc.size() - sb !== 1) begin
            n_fail++;
            $display("FAIL single_start_pulses: got %0d want 1", start_cyc.size() - sb);
        end
        n_cmp++;
        if (valid_cyc[vb] - start_cyc[sb] !== 4) begin
            n_fail++;
            $display("FAIL single_latency: got %0d want 4", valid_cyc[vb] - start_cyc[sb]);
        end
    endtask

    task automatic test_flags();
        bit ok;
        int rb;
        rb = res_p.size();
        mdl_lat = 1;
        push(tab_a[8], tab_b[8], ok);
        wait_results(rb + 1, "flags_wait");
        n_cmp++;
        if ({res_p[rb], res_f[rb]} !== {32'h7F800000, 5'b00010}) begin
            n_fail++;
            $display("FAIL flags_result: got %h/%b want 7f800000/00010", res_p[rb], res_f[rb]);
        end
        n_cmp++;
        if (issued_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL flags_issued: got %0d want 2", issued_cnt);
        end
    endtask

    task automatic test_fill();
        bit ok;
        int rb, acc;
        rb        = res_p.size();
        acc       = 0;
        mdl_lat   = 1;
        res_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push(tab_a[i], tab_b[i], ok);
            if (ok) acc++;
        end
        n_cmp++;
        if (acc !== 5) begin
            n_fail++;
            $display("FAIL fill_accepts: got %0d want 5", acc);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got in_ready %b want 0", in_ready);
        end
        @(posedge clk);
        #1;
        step(3);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, res_valid} !== 2'b01) begin
            n_fail++;
            $display("FAIL fill_hold: got ready/valid %b%b want 01", in_ready, res_valid);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        push(tab_a[6], tab_b[6], ok);
        n_cmp++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_sixth_push: got %b want 1", ok);
        end
        wait_results(rb + 6, "fill_wait");
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if ({res_p[rb + i], res_f[rb + i]} !== {tab_p[i + 1], 5'b00000}) begin
                n_fail++;
                $display("FAIL fill_order[%0d]: got %h/%b want %h/00000",
                         i, res_p[rb + i], res_f[rb + i], tab_p[i + 1]);
            end
        end
        step(10);
        n_cmp++;
        if (res_p.size() !== rb + 6) begin
            n_fail++;
            $display("FAIL fill_no_dup: got %0d results want %0d", res_p.size() - rb, 6);
        end
        n_cmp++;
        if (issued_cnt !== 16'd8) begin
            n_fail++;
            $display("FAIL fill_issued: got %0d want 8", issued_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int rb, sb;
        rb        = res_p.size();
        sb        = start_cyc.size();
        mdl_lat   = 1;
        res_ready = 1'b1;
        push(tab_a[2], tab_b[2], ok);
        push(tab_a[3], tab_b[3], ok);
        wait_results(rb + 2, "b2b_wait");
        n_cmp++;
        if (start_cyc[sb + 1] - start_cyc[sb] !== 4) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d want 4", start_cyc[sb + 1] - start_cyc[sb]);
        end
        n_cmp++;
        if ({res_p[rb], res_p[rb + 1]} !== {tab_p[2], tab_p[3]}) begin
            n_fail++;
            $display("FAIL b2b_results: got %h %h want %h %h",
                     res_p[rb], res_p[rb + 1], tab_p[2], tab_p[3]);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int rb, sb, vb, k;
        rb        = res_p.size();
        sb        = start_cyc.size();
        vb        = valid_cyc.size();
        mdl_lat   = TMO + 4;
        res_ready = 1'b1;
        push(tab_a[4], tab_b[4], ok);
        k = 0;
        while (valid_cyc.size() <= vb && k < 200) begin
            step(1);
            k++;
        end
        n_cmp++;
        if (valid_cyc[vb] - start_cyc[sb] !== TMO + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d want %0d",
                     valid_cyc[vb] - start_cyc[sb], TMO + 1);
        end
        wait_results(rb + 1, "timeout_wait");
        n_cmp++;
        if ({res_p[rb], res_f[rb]} !== {32'h7FC00000, 5'b10000}) begin
            n_fail++;
            $display("FAIL timeout_result: got %h/%b want 7fc00000/10000", res_p[rb], res_f[rb]);
        end
        n_cmp++;
        if (timeout_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d want 1", timeout_cnt);
        end
        step(20);
        n_cmp++;
        if ({res_p.size() - rb, res_valid, issued_cnt} !== {32'd1, 1'b0, 16'd11}) begin
            n_fail++;
            $display("FAIL timeout_late_done: got results %0d valid %b issued %0d want 1 0 11",
                     res_p.size() - rb, res_valid, issued_cnt);
        end
    endtask

    task automatic test_reset_in_start();
        bit ok;
        logic [127:0] snap;
        mdl_lat = 0;
        push(tab_a[5], tab_b[5], ok);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (mul_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_start_pre: got %b want 1", mul_start);
        end
        #1 rst_n = 1'b0;
        #1;
        snap = {mul_a, mul_b, mul_start, res_valid, res_product, res_flags, issued_cnt,
                timeout_cnt, in_ready};
        n_cmp++;
        if (snap !== 128'h1) begin
            n_fail++;
            $display("FAIL rst_start_async: got %h want %h", snap, 128'h1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int rb, sc;
        logic [127:0] snap;
        mdl_lat   = 0;
        res_ready = 1'b1;
        push(tab_a[1], tab_b[1], ok);
        push(tab_a[2], tab_b[2], ok);
        step(4);
        n_cmp++;
        if ({issued_cnt, mul_start, res_valid} !== {16'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_wait_pre: got issued %0d start %b valid %b want 1 0 0",
                     issued_cnt, mul_start, res_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        snap = {mul_a, mul_b, mul_start, res_valid, res_product, res_flags, issued_cnt,
                timeout_cnt, in_ready};
        n_cmp++;
        if (snap !== 128'h1) begin
            n_fail++;
            $display("FAIL rst_wait_async: got %h want %h", snap, 128'h1);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sc = start_cyc.size();
        step(5);
        n_cmp++;
        if (start_cyc.size() !== sc) begin
            n_fail++;
            $display("FAIL rst_wait_flushed: got %0d starts want 0", start_cyc.size() - sc);
        end
        rb      = res_p.size();
        mdl_lat = 1;
        push(tab_a[0], tab_b[0], ok);
        wait_results(rb + 1, "rst_wait_fresh");
        n_cmp++;
        if ({res_p[rb], res_f[rb], issued_cnt} !== {tab_p[0], 5'b00000, 16'd1}) begin
            n_fail++;
            $display("FAIL rst_wait_fresh_result: got %h/%b issued %0d want %h/00000 1",
                     res_p[rb], res_f[rb], issued_cnt, tab_p[0]);
        end
    endtask

    task automatic test_integrity();
        n_cmp++;
        if (orphans !== 0) begin
            n_fail++;
            $display("FAIL orphan_valid: got %0d want 0", orphans);
        end
        n_cmp++;
        if ({res_p.size(), start_cyc.size()} !== {32'd12, 32'd14}) begin
            n_fail++;
            $display("FAIL totals: got results %0d starts %0d want 12 14",
                     res_p.size(), start_cyc.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_flags();
        test_fill();
        test_back_to_back();
        test_timeout();
        test_reset_in_start();
        test_reset_in_wait();
        test_integrity();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
